// File: rtl/mem_responder.sv
// mem_responder
// ------------------------------------------------------------------------------
// Memory-side responder for the execute unit's load/store port. It holds a
// word-organised data RAM and answers one request at a time. Stores may be
// byte, halfword or word wide. Loads return the addressed byte at bit 0, with
// the upper bytes zero-filled.
//
// Transaction flow: IDLE -> (WR_WAIT | RD_WAIT) -> RESP -> IDLE.
// A WAIT state lasts LATENCY-1 cycles, so with a latency of 1 the FSM goes
// from IDLE straight to RESP. Each response is a single-cycle pulse.
//
// Parameters:
//   DEPTH      number of 32-bit words (power of two)
//   RD_LATENCY cycles from read-request sample to o_rd_valid (>= 1)
//   WR_LATENCY cycles from write-request sample to o_wr_ready (>= 1)
//
// Ports:
//   i_clk       clock; all state changes on the rising edge
//   i_rst       asynchronous, active-high reset
//   i_addr      byte address of the request
//   i_data      store data, with the payload in the low bytes
//   i_wr_valid  write request
//   i_wr_width  store width in bytes (1, 2 or 4)
//   o_wr_ready  one-cycle pulse: write committed
//   o_data      load data, with the addressed byte at bit 0
//   i_rd_ready  read request
//   o_rd_valid  one-cycle pulse: o_data is valid
//   o_err       one-cycle pulse alongside the response of a faulting access
//
// Optional feature: define MEM_RESPONDER_BOUNDS_CHECK_EN to fault accesses at
// or above DEPTH*4. A faulting write is dropped and a faulting read returns 0.
// Without the macro, the upper address bits are ignored and the address wraps.
// ------------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module mem_responder #(
    parameter int DEPTH      = 1024,
    parameter int RD_LATENCY = 1,
    parameter int WR_LATENCY = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [31:0]            i_addr,
    input  logic [`DATA_WIDTH-1:0] i_data,
    input  logic                   i_wr_valid,
    input  logic [2:0]             i_wr_width,
    output logic                   o_wr_ready,
    output logic [`DATA_WIDTH-1:0] o_data,
    input  logic                   i_rd_ready,
    output logic                   o_rd_valid,
    output logic                   o_err
);

    localparam int AW     = $clog2(DEPTH);
    localparam int MAXLAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int CW     = (MAXLAT > 2) ? $clog2(MAXLAT) : 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WR_WAIT = 2'd1;
    localparam logic [1:0] RD_WAIT = 2'd2;
    localparam logic [1:0] RESP    = 2'd3;

    logic [1:0]             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   is_wr_q, is_wr_d;
    logic [31:0]            addr_q, addr_d;
    logic [`DATA_WIDTH-1:0] data_q, data_d;
    logic [2:0]             width_q, width_d;

    logic [31:0]            mem [DEPTH];
    logic [31:0]            rd_word_q;
    logic [AW-1:0]          rd_idx;
    logic [AW-1:0]          wr_idx;
    logic [1:0]             lane;
    logic [3:0]             be;
    logic [31:0]            wdata;
    logic                   size_fault;
    logic                   oob;
    logic                   wr_fault;
    logic                   resp;
    logic                   we;
    logic                   wr_done;
    logic                   rd_done;

    // WAIT lasts LATENCY-1 cycles. The counter runs 0..LATENCY-2, so the
    // last WAIT cycle is the one where it equals LATENCY-2.
    assign wr_done = (cnt_q == CW'(WR_LATENCY - 2));
    assign rd_done = (cnt_q == CW'(RD_LATENCY - 2));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        is_wr_d = is_wr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        width_d = width_q;
        case (state_q)
            IDLE: begin
                if (i_wr_valid) begin
                    is_wr_d = 1'b1;
                    addr_d  = i_addr;
                    data_d  = i_data;
                    width_d = i_wr_width;
                    cnt_d   = '0;
                    state_d = (WR_LATENCY > 1) ? WR_WAIT : RESP;
                end else if (i_rd_ready) begin
                    is_wr_d = 1'b0;
                    addr_d  = i_addr;
                    cnt_d   = '0;
                    state_d = (RD_LATENCY > 1) ? RD_WAIT : RESP;
                end
            end
            // A request dropped while waiting aborts the transaction silently.
            WR_WAIT: begin
                if (!i_wr_valid)  state_d = IDLE;
                else if (wr_done) state_d = RESP;
                else              cnt_d   = cnt_q + 1'b1;
            end
            RD_WAIT: begin
                if (!i_rd_ready)  state_d = IDLE;
                else if (rd_done) state_d = RESP;
                else              cnt_d   = cnt_q + 1'b1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            is_wr_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            width_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            is_wr_q <= is_wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            width_q <= width_d;
        end
    end

    assign lane   = addr_q[1:0];
    assign wr_idx = addr_q[AW+1:2];

    always_comb begin
        size_fault = 1'b1;
        be         = 4'b0000;
        case (width_q)
            3'd1: begin size_fault = 1'b0;          be = 4'b0001 << lane; end
            3'd2: begin size_fault = (lane == 2'd3); be = 4'b0011 << lane; end
            3'd4: begin size_fault = (lane != 2'd0); be = 4'b1111;         end
            default: begin size_fault = 1'b1;       be = 4'b0000;         end
        endcase
    end

`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
    assign oob = (addr_q >= 32'(DEPTH * 4));
`else
    // Upper address bits are deliberately ignored; the address wraps.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_q[31:AW+2];
    assign oob = 1'b0;
`endif

    assign wr_fault = size_fault | oob;
    assign resp     = (state_q == RESP);
    assign wdata    = data_q << {lane, 3'b000};

    // The RAM commits on the edge that closes the RESP cycle. A reset during
    // RESP therefore also discards the write.
    assign we = resp & is_wr_q & ~wr_fault;

    // Registered RAM read. In IDLE the incoming address is looked up, so a
    // latency-1 read has its word ready in RESP. In RD_WAIT the latched
    // address is re-read each cycle.
    assign rd_idx = (state_q == IDLE) ? i_addr[AW+1:2] : addr_q[AW+1:2];

    always_ff @(posedge i_clk) begin
        rd_word_q <= mem[rd_idx];
    end

    always_ff @(posedge i_clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[wr_idx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    assign o_wr_ready = resp & is_wr_q;
    assign o_rd_valid = resp & ~is_wr_q;
    assign o_err      = resp & (is_wr_q ? wr_fault : oob);
    assign o_data     = (o_rd_valid && !oob) ? (rd_word_q >> {lane, 3'b000}) : '0;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        i_rst;
    logic [31:0] i_addr;
    logic [31:0] i_data;
    logic        i_wr_valid;
    logic [2:0]  i_wr_width;
    logic        i_rd_ready;

    logic [2:0]  wr_ready_v;
    logic [2:0]  rd_valid_v;
    logic [2:0]  err_v;
    logic [31:0] data_v [3];

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    // Three instances share the request inputs:
    //   d0: RD=1, WR=1
    //   d1: RD=2, WR=1
    //   d2: RD=3, WR=2
    mem_responder #(.DEPTH(1024), .RD_LATENCY(1), .WR_LATENCY(1)) d0 (
        .i_clk(clk), .i_rst(i_rst), .i_addr(i_addr), .i_data(i_data),
        .i_wr_valid(i_wr_valid), .i_wr_width(i_wr_width), .o_wr_ready(wr_ready_v[0]),
        .o_data(data_v[0]), .i_rd_ready(i_rd_ready), .o_rd_valid(rd_valid_v[0]),
        .o_err(err_v[0]));
    mem_responder #(.DEPTH(1024), .RD_LATENCY(2), .WR_LATENCY(1)) d1 (
        .i_clk(clk), .i_rst(i_rst), .i_addr(i_addr), .i_data(i_data),
        .i_wr_valid(i_wr_valid), .i_wr_width(i_wr_width), .o_wr_ready(wr_ready_v[1]),
        .o_data(data_v[1]), .i_rd_ready(i_rd_ready), .o_rd_valid(rd_valid_v[1]),
        .o_err(err_v[1]));
    mem_responder #(.DEPTH(1024), .RD_LATENCY(3), .WR_LATENCY(2)) d2 (
        .i_clk(clk), .i_rst(i_rst), .i_addr(i_addr), .i_data(i_data),
        .i_wr_valid(i_wr_valid), .i_wr_width(i_wr_width), .o_wr_ready(wr_ready_v[2]),
        .o_data(data_v[2]), .i_rd_ready(i_rd_ready), .o_rd_valid(rd_valid_v[2]),
        .o_err(err_v[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Called at a negedge while every instance is IDLE.
    // Returns at the negedge after the response.
    task automatic do_write(input int sel, input logic [31:0] a, input logic [31:0] d,
                            input logic [2:0] w, input logic exp_err, input int exp_lat,
                            input string tag);
        int cnt;
        i_addr = a; i_data = d; i_wr_width = w; i_wr_valid = 1'b1;
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (!wr_ready_v[sel] && cnt < 12);
        $display("write %s sel=%0d addr=%h data=%h width=%0d lat=%0d err=%b",
                 tag, sel, a, d, w, cnt, err_v[sel]);
        check({tag, " wr_ready"}, 32'(wr_ready_v[sel]), 32'd1);
        check({tag, " wr_lat"}, cnt, exp_lat);
        check({tag, " err"}, 32'(err_v[sel]), 32'(exp_err));
        i_wr_valid = 1'b0;
        @(negedge clk);
        check({tag, " pulse_drop"}, {30'd0, wr_ready_v[sel], err_v[sel]}, 32'd0);
    endtask

    task automatic do_read(input int sel, input logic [31:0] a, input logic [31:0] exp_d,
                           input logic exp_err, input int exp_lat, input string tag);
        int cnt;
        i_addr = a; i_rd_ready = 1'b1;
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (!rd_valid_v[sel] && cnt < 12);
        $display("read  %s sel=%0d addr=%h data=%h lat=%0d err=%b",
                 tag, sel, a, data_v[sel], cnt, err_v[sel]);
        check({tag, " rd_valid"}, 32'(rd_valid_v[sel]), 32'd1);
        check({tag, " rd_lat"}, cnt, exp_lat);
        check({tag, " data"}, data_v[sel], exp_d);
        check({tag, " err"}, 32'(err_v[sel]), 32'(exp_err));
        i_rd_ready = 1'b0;
        @(negedge clk);
        check({tag, " valid_drop"}, {31'd0, rd_valid_v[sel]}, 32'd0);
        check({tag, " data_zero"}, data_v[sel], 32'd0);
    endtask

    initial begin
        int cnt;
        int seen;
        i_rst = 1'b1; i_addr = '0; i_data = '0; i_wr_valid = 1'b0;
        i_wr_width = 3'd0; i_rd_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_flags", {23'd0, wr_ready_v, rd_valid_v, err_v}, 32'd0);
        check("reset_data", data_v[0] | data_v[1] | data_v[2], 32'd0);
        i_rst = 1'b0;
        @(negedge clk);

        // Word store and load.
        do_write(0, 32'h10, 32'hDEADBEEF, 3'd4, 1'b0, 1, "sw10");
        do_read (0, 32'h10, 32'hDEADBEEF, 1'b0, 1, "lw10");

        // Byte and halfword lanes.
        do_write(0, 32'h11, 32'h00000055, 3'd1, 1'b0, 1, "sb11");
        do_write(0, 32'h12, 32'h0000A1B2, 3'd2, 1'b0, 1, "sh12");
        do_read (0, 32'h10, 32'hA1B255EF, 1'b0, 1, "rd10");
        do_read (0, 32'h11, 32'h00A1B255, 1'b0, 1, "rd11");
        do_read (0, 32'h13, 32'h000000A1, 1'b0, 1, "rd13");

        // Faulting stores are dropped but still acknowledged.
        do_write(0, 32'h13, 32'h0000FFFF, 3'd2, 1'b1, 1, "sh13_fault");
        do_read (0, 32'h10, 32'hA1B255EF, 1'b0, 1, "rd_after_sh13");
        do_write(0, 32'h12, 32'h77777777, 3'd4, 1'b1, 1, "sw12_fault");
        do_read (0, 32'h10, 32'hA1B255EF, 1'b0, 1, "rd_after_sw12");
        do_write(0, 32'h10, 32'h33333333, 3'd3, 1'b1, 1, "w3_fault");
        do_read (0, 32'h10, 32'hA1B255EF, 1'b0, 1, "rd_after_w3");

        // Burst on the RD_LATENCY=2 instance.
        for (int i = 0; i < 8; i++)
            do_write(0, 32'h100 + 32'(i * 4), 32'hC0DE0000 + 32'(i), 3'd4, 1'b0, 1, "burst_fill");
        i_rd_ready = 1'b1;
        for (int b = 0; b < 8; b++) begin
            i_addr = 32'h100 + 32'(b * 4);
            cnt = 0;
            do begin @(negedge clk); cnt++; end while (!rd_valid_v[1] && cnt < 12);
            $display("burst beat=%0d addr=%h data=%h gap=%0d", b, i_addr, data_v[1], cnt);
            check("burst_gap", cnt, (b == 0) ? 2 : 3);
            check("burst_data", data_v[1], 32'hC0DE0000 + 32'(b));
        end
        i_rd_ready = 1'b0;
        repeat (5) @(negedge clk);

        // Abort: RD_LATENCY=3 read with the request dropped after one cycle.
        i_addr = 32'h10; i_rd_ready = 1'b1;
        @(negedge clk);
        i_rd_ready = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rd_valid_v[2]) seen++;
        end
        $display("abort valid_pulses=%0d", seen);
        check("abort_no_valid", seen, 0);

        // Reset while d2 is in WR_WAIT and d0 is in RESP.
        do_write(2, 32'h20, 32'h11112222, 3'd4, 1'b0, 2, "sw20_pre");
        i_addr = 32'h20; i_data = 32'h0BADF00D; i_wr_width = 3'd4; i_wr_valid = 1'b1;
        @(negedge clk);
        check("d0_ready_before_rst", 32'(wr_ready_v[0]), 32'd1);
        i_rst = 1'b1;
        #1;
        $display("reset mid-write flags=%b", {wr_ready_v, rd_valid_v, err_v});
        check("rst_flags_now", {23'd0, wr_ready_v, rd_valid_v, err_v}, 32'd0);
        check("rst_data_now", data_v[0] | data_v[1] | data_v[2], 32'd0);
        @(negedge clk);
        i_wr_valid = 1'b0; i_rst = 1'b0;
        @(negedge clk);
        do_read(2, 32'h20, 32'h11112222, 1'b0, 3, "rd20_d2");
        do_read(0, 32'h20, 32'h11112222, 1'b0, 1, "rd20_d0");

        // Bounds.
        do_write(0, 32'h0, 32'hCAFEF00D, 3'd4, 1'b0, 1, "sw0");
`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
        do_write(0, 32'h1000, 32'h12345678, 3'd4, 1'b1, 1, "sw1000");
        do_read (0, 32'h1000, 32'h00000000, 1'b1, 1, "rd1000");
        do_read (0, 32'h0, 32'hCAFEF00D, 1'b0, 1, "rd0");
`else
        do_write(0, 32'h1000, 32'h12345678, 3'd4, 1'b0, 1, "sw1000");
        do_read (0, 32'h1000, 32'h12345678, 1'b0, 1, "rd1000");
        do_read (0, 32'h0, 32'h12345678, 1'b0, 1, "rd0");
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

- Memory-side responder for the execute unit's load/store port: a word-organised data RAM serving byte, halfword and word stores and aligned-lane loads.
- Answers the ready/valid handshakes the execute unit initiates, including back-to-back vector-load bursts.
- Sits between the execute unit and on-chip data storage, replacing the bench-level memory model.

## Interface
- DEPTH, 1024: number of 32-bit words; power of two.
- RD_LATENCY, 1: cycles from read-request sample to o_rd_valid; ≥1.
- WR_LATENCY, 1: cycles from write-request sample to o_wr_ready; ≥1.
- i_clk  in  1  clock, all state on rising edge.
- i_rst  in  1  reset; asynchronous, active-high.
- i_addr  in  32  byte address of the request.
- i_data  in  `DATA_WIDTH (32)  store data; payload in the low bytes.
- i_wr_valid  in  1  write request.
- i_wr_width  in  3  store width in bytes: 1, 2 or 4.
- o_wr_ready  out  1  one-cycle pulse: write committed.
- o_data  out  `DATA_WIDTH (32)  load data, addressed byte at bit 0.
- i_rd_ready  in  1  read request.
- o_rd_valid  out  1  one-cycle pulse: o_data valid.
- o_err  out  1  one-cycle pulse alongside the response of a faulting access.

## Operation
- **Reset values:** o_wr_ready=0, o_rd_valid=0, o_data=0, o_err=0. FSM goes to IDLE and the latency counter clears. RAM contents are not cleared.
- **Address decoding:** word index = i_addr[log2(DEPTH)+1:2]; lane = i_addr[1:0].
- **FSM states:** IDLE, WR_WAIT, RD_WAIT, RESP.
- **IDLE:**
  - If i_wr_valid, latch addr, data and width, then go to WR_WAIT.
  - Else if i_rd_ready, latch addr and go to RD_WAIT.
  - Write wins when both are high.
- **WR_WAIT:**
  - Count WR_LATENCY-1 cycles, then go to RESP.
  - o_wr_ready=1 in RESP.
  - The RAM byte-enables update on the RESP cycle's clock edge.
- **RD_WAIT:**
  - Count RD_LATENCY-1 cycles, then go to RESP.
  - In RESP: o_rd_valid=1 and o_data = word >> (lane*8).
  - Upper bytes are zero-filled; the initiator extends sign or zero itself.
- **RESP:**
  - Always returns to IDLE on the next cycle.
  - A new request is sampled in that IDLE cycle, so burst throughput is one beat per max(latency)+1 cycles. The initiator may change i_addr after the valid beat.
- **Store lanes:** data << (lane*8). Byte enables: width 1 gives {lane}; width 2 gives {lane, lane+1}; width 4 gives all four lanes.
- **Faults (write dropped, o_err pulsed in RESP, o_wr_ready still pulses):**
  - width not in {1,2,4};
  - halfword with lane=3;
  - word with lane≠0.
- **Misaligned reads:** not faults; they return the shifted word.
- **Abort:** if the request signal that started a transaction (i_wr_valid or i_rd_ready) drops during a WAIT state, return to IDLE with no response and no RAM write.
- **Reset mid-transaction:** pending response discarded; no RAM write occurs.

## Timing
- **Write:** request sampled at edge N → o_wr_ready high during cycle N+WR_LATENCY. Data is readable by a read sampled at N+WR_LATENCY+1 or later.
- **Read:** request sampled at edge N → o_rd_valid and o_data during cycle N+RD_LATENCY, held for exactly one cycle. o_data returns to 0 afterwards.
- **Output hold:** o_wr_ready, o_rd_valid and o_err are never high for two consecutive cycles.
- **Request hold:** the initiator holds its request and fields until the response; fields are latched in IDLE, so later changes are ignored.

## Configuration
- **Macro:** MEM_RESPONDER_BOUNDS_CHECK_EN.
- **Defined:**
  - Faulting condition: i_addr ≥ DEPTH*4.
  - Writes are dropped and reads return o_data=0.
  - In both cases o_err pulses with the response.
- **Undefined:** upper address bits are ignored, so the address wraps modulo DEPTH*4 and no out-of-range fault exists.

## Test plan
- **Word store/load:**
  - Stimulus: SW 0xDEADBEEF @0x10, then read @0x10.
  - Response: o_wr_ready at +1; o_rd_valid at +1 with o_data=0xDEADBEEF; o_err=0.
- **Byte/halfword lanes:**
  - Stimulus: after the above, SB 0x55 @0x11, then SH 0xA1B2 @0x12.
  - Response:
    - read @0x10 → 0xA1B255EF;
    - read @0x11 → 0x00A1B255;
    - read @0x13 → 0x000000A1.
- **Faults:**
  - Stimulus: SH @0x13 and SW @0x12, each followed by a read of the target word.
  - Response: o_err pulses with o_wr_ready for each; word unchanged.
- **Burst (RD_LATENCY=2):**
  - Stimulus: 8 reads @0x100,0x104…0x11C, address advanced after each valid.
  - Response: eight valid pulses spaced 3 cycles apart with the correct words.
- **Abort and reset:**
  - Abort: read with RD_LATENCY=3, i_rd_ready dropped after 1 cycle → no o_rd_valid.
  - Reset: i_rst asserted during WR_WAIT → all outputs 0 immediately; target word unchanged.
- **Bounds (DEPTH=1024):**
  - Stimulus: write 0x12345678 @0x1000, then read @0x1000 and read @0x0.
  - With MEM_RESPONDER_BOUNDS_CHECK_EN: o_err pulses on both the write and the read @0x1000, which returns 0; word 0 unchanged.
  - Without: word 0 = 0x12345678; no o_err.
